// File: rtl/regfile_arbiter_pkg.sv
// Shared types and defaults for the register-file sequencer/arbiter.
package regfile_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 4;
  localparam int unsigned DEPTH_DEFAULT  = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    INIT,
    ARB,
    ISSUE
  } state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the arbiter: two request channels plus shared read data.
interface regfile_arbiter_if
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, ready
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, ready
  );

endinterface

// File: rtl/regfile_arbiter_rr_select.sv
// Combinational 2-way round-robin pick; the last-winner flag lives in the caller.
module rr_select
  import regfile_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic id
);

  always_comb begin
    valid = req_a | req_b;
    id    = REQ_A;
    if (req_a && req_b) id = ~last;
    else if (req_b)     id = REQ_B;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Init sweep of the register file, then round-robin arbitration of its
// single write port and single read port between requesters A and B.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data
);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              sweep_on;
  logic              last;
  logic              win;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              sel_valid;
  logic              sel_id;

  rr_select u_rr_select (
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .last  (last),
    .valid (sel_valid),
    .id    (sel_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= INIT;
      cnt          <= '0;
      sweep_on     <= 1'b0;
      last         <= REQ_B;
      win          <= REQ_A;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      rd_addr_q    <= '0;
      bus.gnt_a    <= 1'b0;
      bus.gnt_b    <= 1'b0;
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;
      bus.rdata    <= '0;
      bus.ready    <= 1'b0;
    end else begin
      bus.gnt_a    <= 1'b0;
      bus.gnt_b    <= 1'b0;
      bus.rvalid_a <= 1'b0;
      bus.rvalid_b <= 1'b0;
      unique case (state)
        INIT: begin
          // First edge after reset only arms the sweep so rf_write stays low in reset
          if (!sweep_on) begin
            sweep_on <= 1'b1;
          end else if (cnt == (ADDR_W+1)'(DEPTH - 1)) begin
            state     <= ARB;
            bus.ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB: begin
          if (sel_valid) begin
            win <= sel_id;
            if (sel_id == REQ_B) begin
              lat_we    <= bus.we_b;
              lat_addr  <= bus.addr_b;
              lat_wdata <= bus.wdata_b;
              bus.gnt_b <= 1'b1;
            end else begin
              lat_we    <= bus.we_a;
              lat_addr  <= bus.addr_a;
              lat_wdata <= bus.wdata_a;
              bus.gnt_a <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          last <= win;
          if (!lat_we) begin
            bus.rdata <= rf_rd_data;
            rd_addr_q <= lat_addr;
            if (win == REQ_B) bus.rvalid_b <= 1'b1;
            else              bus.rvalid_a <= 1'b1;
          end
          state <= ARB;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    rf_write   = ((state == INIT) && sweep_on) || ((state == ISSUE) && lat_we);
    rf_wr_addr = lat_addr;
    rf_wr_data = lat_wdata;
    if (state == INIT) begin
      rf_wr_addr = cnt[ADDR_W-1:0];
      rf_wr_data = '0;
    end
    rf_rd_addr = ((state == ISSUE) && !lat_we) ? lat_addr : rd_addr_q;
  end

endmodule
